// File: rtl/keypad_pkg.sv
// Shared types and helpers for the 4x4 matrix keypad scanner.
// Contents: scan FSM state enum, key code type, idle row pattern, row priority encoder.
package keypad_pkg;

    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        HELD,
        RELEASE
    } kp_state_t;

    typedef logic [3:0] key_code_t;

    localparam logic [3:0] ROWS_IDLE = 4'b1111;

    // Lowest-index row pulled low; only meaningful when rows != ROWS_IDLE.
    function automatic logic [1:0] first_low(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/keypad_tick_gen.sv
// Scan prescaler: counts 0..SCAN_DIV-1 and flags the last count as the scan tick.
// Ports: clk, rst (sync, active-high), tick (high for one clk every SCAN_DIV clks).
module keypad_tick_gen #(
    parameter int SCAN_DIV = 16384
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(SCAN_DIV - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign tick = (cnt_q == LAST);

    always_comb begin
        cnt_d = tick ? '0 : cnt_q + CW'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

endmodule

// File: rtl/matrix_keypad_scanner.sv
// 4x4 active-low keypad scanner: one column driven at a time, rows synchronized,
// first pressed key debounced and reported as {col,row} with a one-clk key_valid.
// Ports: clk, rst (sync, active-high), row_n[3:0] in, col_n[3:0], key_code[3:0],
//        key_valid, key_held out.
// Option: define KEYPAD_REPEAT_EN for auto-repeat strobes every REPEAT_TICKS ticks.
module matrix_keypad_scanner import keypad_pkg::*; #(
    parameter int SCAN_DIV       = 16384,
    parameter int DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_TICKS   = 256
`endif
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [3:0]      row_n,
    output logic [3:0]      col_n,
    output key_code_t       key_code,
    output logic            key_valid,
    output logic            key_held
);

    localparam logic [7:0] DB_N = 8'(DEBOUNCE_SCANS);

    logic       tick;
    logic [3:0] sync1_q;
    logic [3:0] rs_q;

    kp_state_t  state_q, state_d;
    logic [1:0] col_q, col_d;
    key_code_t  cand_q, cand_d;
    key_code_t  code_q, code_d;
    logic [7:0] cnt_q, cnt_d;
    logic       valid_q, valid_d;
    logic       held_q, held_d;

    logic       press;
    logic [1:0] row_hit;
    logic       cand_low;
    logic [7:0] cnt_inc;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = $clog2(REPEAT_TICKS + 1);
    localparam logic [RW-1:0] REP_N = RW'(REPEAT_TICKS);
    logic [RW-1:0] rep_q, rep_d;
    logic [RW-1:0] rep_inc;
    assign rep_inc = rep_q + RW'(1);
`endif

    keypad_tick_gen #(
        .SCAN_DIV(SCAN_DIV)
    ) u_tick (
        .clk (clk),
        .rst (rst),
        .tick(tick)
    );

    assign press    = (rs_q != ROWS_IDLE);
    assign row_hit  = first_low(rs_q);
    assign cand_low = ~rs_q[cand_q[1:0]];
    assign cnt_inc  = cnt_q + 8'd1;

    assign col_n     = ~(4'b0001 << col_q);
    assign key_code  = code_q;
    assign key_valid = valid_q;
    assign key_held  = held_q;

    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        cand_d  = cand_q;
        code_d  = code_q;
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
        rep_d   = rep_q;
`endif
        if (tick) begin
            unique case (state_q)
                SCAN: begin
                    if (!press) begin
                        col_d = col_q + 2'd1;
                    end else begin
                        cand_d = {col_q, row_hit};
                        if (DB_N == 8'd1) begin
                            // single-scan debounce accepts on the detecting tick
                            code_d  = {col_q, row_hit};
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end else begin
                            cnt_d   = 8'd1;
                            state_d = DEBOUNCE;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (cand_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_N) begin
                            code_d  = cand_q;
                            valid_d = 1'b1;
                            held_d  = 1'b1;
                            state_d = HELD;
`ifdef KEYPAD_REPEAT_EN
                            rep_d   = '0;
`endif
                        end
                    end else begin
                        state_d = SCAN;
                        col_d   = col_q + 2'd1;
                    end
                end
                HELD: begin
                    if (!cand_low) begin
                        if (DB_N == 8'd1) begin
                            held_d  = 1'b0;
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end else begin
                            cnt_d   = 8'd1;
                            state_d = RELEASE;
                        end
                    end else begin
`ifdef KEYPAD_REPEAT_EN
                        if (rep_inc == REP_N) begin
                            rep_d   = '0;
                            valid_d = 1'b1;
                        end else begin
                            rep_d = rep_inc;
                        end
`endif
                    end
                end
                RELEASE: begin
                    if (!cand_low) begin
                        cnt_d = cnt_inc;
                        if (cnt_inc == DB_N) begin
                            held_d  = 1'b0;
                            state_d = SCAN;
                            col_d   = col_q + 2'd1;
                        end
                    end else begin
                        // bounce back to pressed: no new strobe
                        state_d = HELD;
                    end
                end
                default: state_d = SCAN;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= ROWS_IDLE;
            rs_q    <= ROWS_IDLE;
            state_q <= SCAN;
            col_q   <= 2'd0;
            cand_q  <= '0;
            code_q  <= '0;
            cnt_q   <= 8'd0;
            valid_q <= 1'b0;
            held_q  <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= '0;
`endif
        end else begin
            sync1_q <= row_n;
            rs_q    <= sync1_q;
            state_q <= state_d;
            col_q   <= col_d;
            cand_q  <= cand_d;
            code_q  <= code_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            held_q  <= held_d;
`ifdef KEYPAD_REPEAT_EN
            rep_q   <= rep_d;
`endif
        end
    end

endmodule

// File: tb/tb_matrix_keypad_scanner.sv
// Scoreboard bench for matrix_keypad_scanner (SCAN_DIV=4, DEBOUNCE_SCANS=3).
// Keypad model closes row lines from a key mask against the driven column.
module tb_matrix_keypad_scanner;
    import keypad_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] row_n;
    logic [3:0] col_n;
    key_code_t  key_code;
    logic       key_valid;
    logic       key_held;

    logic [15:0] keymask = 16'h0000;
    key_code_t   exp_q[$];
    int          n_cmp = 0;
    int          n_bad = 0;

    matrix_keypad_scanner #(
        .SCAN_DIV      (4),
        .DEBOUNCE_SCANS(3)
`ifdef KEYPAD_REPEAT_EN
        ,
        .REPEAT_TICKS  (8)
`endif
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .row_n    (row_n),
        .col_n    (col_n),
        .key_code (key_code),
        .key_valid(key_valid),
        .key_held (key_held)
    );

    always #5 clk = ~clk;

    always_comb begin
        row_n = 4'hF;
        for (int c = 0; c < 4; c++)
            if (!col_n[c])
                for (int r = 0; r < 4; r++)
                    if (keymask[4*c+r]) row_n[r] = 1'b0;
    end

    task automatic check(input string name, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic monitor();
        key_code_t e;
        forever begin
            @(negedge clk);
            if (key_valid === 1'b1) begin
                n_cmp++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL strobe: got code %h, expected no strobe", key_code);
                end else begin
                    e = exp_q.pop_front();
                    if (key_code !== e || key_held !== 1'b1) begin
                        n_bad++;
                        $display("FAIL strobe: got code %h held %b, expected %h held 1",
                                 key_code, key_held, e);
                    end
                end
            end
        end
    endtask

    task automatic wait_held(input logic v, input int bound, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (key_held !== v && n < bound);
        if (key_held !== v) begin
            n_cmp++;
            n_bad++;
            $display("FAIL wait_held: got %b after %0d clk, expected %b", key_held, n, v);
        end
    endtask

    task automatic wait_col(input logic [3:0] c, input int bound);
        logic [3:0] prev;
        int n;
        prev = col_n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            if (col_n == c && prev != c) return;
            prev = col_n;
        end while (n < bound);
        n_cmp++;
        n_bad++;
        $display("FAIL wait_col: got %b, expected fresh %b", col_n, c);
    endtask

    task automatic press_release(input logic [15:0] m, input key_code_t code, input string tag);
        int n;
        exp_q.push_back(code);
        keymask = m;
        wait_held(1'b1, 200, n);
        keymask = 16'h0000;
        wait_held(1'b0, 40, n);
        check({tag, "_rel_lat"}, int'(n >= 11 && n <= 14), 1);
    endtask

    task automatic run_tests();
        logic [3:0] seen_col [4];
        int         seen_at  [4];
        logic [3:0] exp_cols [4];
        logic [3:0] prev;
        int         k;
        int         n;

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_col_n", int'(col_n), 'he);
        check("rst_code", int'(key_code), 0);
        check("rst_valid", int'(key_valid), 0);
        check("rst_held", int'(key_held), 0);
        rst = 1'b0;

        // idle scan: one column step every 4 clk
        exp_cols[0] = 4'b1101;
        exp_cols[1] = 4'b1011;
        exp_cols[2] = 4'b0111;
        exp_cols[3] = 4'b1110;
        prev = col_n;
        k = 0;
        for (int i = 1; i <= 17; i++) begin
            @(negedge clk);
            if (col_n != prev && k < 4) begin
                seen_col[k] = col_n;
                seen_at[k]  = i;
                k++;
            end
            prev = col_n;
        end
        check("idle_steps", k, 4);
        for (int j = 0; j < 4; j++) begin
            check("idle_col", int'(seen_col[j]), int'(exp_cols[j]));
            check("idle_step_at", seen_at[j], 4 * (j + 1));
        end

        // clean press col 2 row 1
        exp_q.push_back(4'h9);
        keymask = 16'h0200;
        wait_held(1'b1, 200, n);
        check("held_col_frozen", int'(col_n), 'hb);
        keymask = 16'h0000;
        wait_held(1'b0, 40, n);
        check("clean_rel_lat", int'(n >= 11 && n <= 14), 1);
        check("scan_resumes", int'(col_n), 'h7);

        // bounce: low 1 tick, high 1 tick, then steady low
        wait_col(4'b1011, 40);
        keymask = 16'h0200;
        repeat (5) @(negedge clk);
        keymask = 16'h0000;
        repeat (4) @(negedge clk);
        check("bounce_no_held", int'(key_held), 0);
        check("bounce_code_kept", int'(key_code), 'h9);
        press_release(16'h0200, 4'h9, "bounce");

        // two keys in column 0: rows 3 and 1, lowest row wins
        press_release(16'h000a, 4'h1, "twokey");

        // reset while debouncing col 0 row 2
        wait_col(4'b1110, 40);
        keymask = 16'h0004;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_col_n", int'(col_n), 'he);
        check("midrst_code", int'(key_code), 0);
        check("midrst_valid", int'(key_valid), 0);
        check("midrst_held", int'(key_held), 0);
        rst = 1'b0;
        keymask = 16'h0000;
        repeat (60) @(negedge clk);
        check("midrst_still_idle", int'(key_held), 0);

        // long hold: 37 ticks in HELD with the row low
        exp_q.push_back(4'h6);
`ifdef KEYPAD_REPEAT_EN
        repeat (4) exp_q.push_back(4'h6);
`endif
        keymask = 16'h0040;
        wait_held(1'b1, 200, n);
        repeat (150) @(negedge clk);
        check("long_hold_code", int'(key_code), 'h6);
        keymask = 16'h0000;
        wait_held(1'b0, 40, n);
        repeat (8) @(negedge clk);
    endtask

    initial begin
        fork
            monitor();
            run_tests();
            begin
                repeat (20000) @(posedge clk);
                $display("FAIL watchdog: bench did not complete within 20000 clk");
                $fatal(1, "watchdog");
            end
        join_any
        check("strobes_outstanding", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
